woz_track_rw: RTL

//  Parametrised read/write WOZ track buffer between the SD block interface and flux_drive.

---
 rtl/woz_pkg.sv | 25 ++
 rtl/woz_track_bram.sv | 30 +++
 rtl/woz_track_rw.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/woz_pkg.sv
// Shared types and constants for the WOZ track buffer: controller states,
// SD block geometry and the block-0 header layout.
package woz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REQ,
        ST_LOAD_WAIT,
        ST_FLUSH_REQ,
        ST_FLUSH_WAIT
    } state_e;

    // Source of the registered write-back byte handed to the SD side.
    typedef enum logic [1:0] {
        DIN_ZERO,
        DIN_HDR,
        DIN_BRAM
    } din_src_e;

    localparam int HDR_BYTES    = 8;
    localparam int SD_BLK_BYTES = 512;
    localparam int HDR_BIT_OFS  = 0;
    localparam int HDR_BYTE_OFS = 4;

endpackage

// File: rtl/woz_track_bram.sv
// Track byte store: port A (SD side) read/write with registered read,
// port B (drive side) write with asynchronous read.
module woz_track_bram #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [7:0]        a_din_i,
    output logic [7:0]        a_dout_o,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [7:0]        b_din_i,
    output logic [7:0]        b_dout_o
);

    logic [7:0] mem_q [2**ADDR_W];
    logic [7:0] a_dout_q;

    // Port A is written last so an SD write wins a same-address collision.
    always_ff @(posedge clk) begin
        if (b_we_i) mem_q[b_addr_i] <= b_din_i;
        if (a_we_i) mem_q[a_addr_i] <= a_din_i;
        a_dout_q <= mem_q[a_addr_i];
    end

    assign a_dout_o = a_dout_q;
    assign b_dout_o = mem_q[b_addr_i];

endmodule

// File: rtl/woz_track_rw.sv
// Read/write WOZ track buffer: loads one track from SD into BRAM, takes drive
// byte writes, and writes dirty tracks back before a switch or on flush.
module woz_track_rw
    import woz_pkg::*;
#(
    parameter int          ADDR_W     = 14,
    parameter int          TRK_W      = 7,
    parameter int          MAX_BLOCKS = 25,
    parameter int          BLK_SHIFT  = 5,
    parameter logic [31:0] LBA_BASE   = 32'd0,
    parameter int          HDR_BYTES  = woz_pkg::HDR_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    output logic [31:0]       sd_lba_o,
    output logic              sd_rd_o,
    output logic              sd_wr_o,
    input  logic              sd_ack_i,
    input  logic [8:0]        sd_buff_addr_i,
    input  logic [7:0]        sd_buff_dout_i,
    input  logic              sd_buff_wr_i,
    output logic [7:0]        sd_buff_din_o,
    input  logic              change_i,
    input  logic              mount_i,
    input  logic              readonly_i,
    input  logic [TRK_W-1:0]  track_i,
    input  logic              side_i,
    input  logic              active_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] bit_byte_addr_i,
    output logic [7:0]        bit_byte_data_o,
    input  logic [7:0]        bit_byte_din_i,
    input  logic              bit_byte_we_i,
    output logic [31:0]       bit_count_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              dirty_o,
    output logic [2:0]        state_o
);

    localparam int SLOT_W   = TRK_W + 1;
    localparam int NB_W     = $clog2(MAX_BLOCKS + 1);
    localparam int BLK_BITS = $clog2(SD_BLK_BYTES);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] cur_slot_q, cur_slot_d, xfer_slot_q, xfer_slot_d;
    logic [NB_W-1:0]   rel_blk_q, rel_blk_d, n_blk_q, n_blk_d;
    logic [31:0]       bit_count_q, bit_count_d, byte_count_q, byte_count_d;
    logic [31:0]       lba_q, lba_d;
    logic              ready_q, ready_d, dirty_q, dirty_d;
    logic              mount_pend_q, mount_pend_d;
    logic              change_q, ack_q;
    din_src_e          din_src_q, din_src_d;
    logic [7:0]        hdr_q;

    logic              change_rise, ack_fall, is_hdr, in_range, last_blk;
    logic              a_we, drv_we;
    logic [SLOT_W-1:0] req_slot;
    logic [31:0]       blk_pos, map_addr, blk_need;
    logic [NB_W-1:0]   n_calc, n_eff;
    logic [5:0]        hdr_idx;
    logic [63:0]       hdr_word, hdr_d;
    logic [7:0]        a_dout, b_dout;

    assign change_rise = change_i & ~change_q;
    assign ack_fall    = ack_q & ~sd_ack_i;
    assign req_slot    = {side_i, track_i};

    // SD byte position inside the track; block 0 starts with the header.
    assign blk_pos  = (32'(rel_blk_q) << BLK_BITS) | 32'(sd_buff_addr_i);
    assign map_addr = blk_pos - 32'(HDR_BYTES);
    assign is_hdr   = (rel_blk_q == '0) && (sd_buff_addr_i < 9'(HDR_BYTES));
    assign in_range = !is_hdr && (map_addr < (32'd1 << ADDR_W));
    assign hdr_idx  = {sd_buff_addr_i[2:0], 3'b000};

    assign blk_need = (byte_count_q + 32'(HDR_BYTES) + 32'(SD_BLK_BYTES - 1)) >> BLK_BITS;
    assign n_calc   = (byte_count_q == 32'd0)          ? NB_W'(1) :
                      (blk_need > 32'(MAX_BLOCKS))     ? NB_W'(MAX_BLOCKS) :
                                                         blk_need[NB_W-1:0];
    assign n_eff    = (state_q == ST_LOAD_WAIT && rel_blk_q == '0) ? n_calc : n_blk_q;
    assign last_blk = (rel_blk_q + NB_W'(1)) == n_eff;

    assign a_we   = (state_q == ST_LOAD_WAIT) & sd_ack_i & sd_buff_wr_i & in_range
                  & ~change_rise & ~reset;
    assign drv_we = bit_byte_we_i & ready_q & ~busy_o & ~readonly_i & ~change_rise;

    always_comb begin
        hdr_word = '0;
        hdr_word[8*HDR_BIT_OFS +: 32]  = bit_count_q;
        hdr_word[8*HDR_BYTE_OFS +: 32] = byte_count_q;
    end

    // SD handshake: a *_REQ state holds sd_rd/sd_wr until sd_ack rises; the
    // block then streams while sd_ack is high and ends on its falling edge.
    always_comb begin
        state_d      = state_q;
        cur_slot_d   = cur_slot_q;
        xfer_slot_d  = xfer_slot_q;
        rel_blk_d    = rel_blk_q;
        n_blk_d      = n_blk_q;
        ready_d      = ready_q;
        dirty_d      = dirty_q | drv_we;
        mount_pend_d = mount_pend_q;
        lba_d        = lba_q;
        hdr_d        = hdr_word;
        din_src_d    = DIN_ZERO;

        unique case (state_q)
            ST_IDLE: begin
                if ((ready_q || mount_pend_q) && !active_i) begin
                    if (req_slot != cur_slot_q && dirty_q) begin
                        state_d     = ST_FLUSH_REQ;
                        xfer_slot_d = cur_slot_q;
                        rel_blk_d   = '0;
                    end else if (req_slot != cur_slot_q) begin
                        state_d     = ST_LOAD_REQ;
                        xfer_slot_d = req_slot;
                        rel_blk_d   = '0;
                        ready_d     = 1'b0;
                    end else if (flush_i && dirty_q && ready_q) begin
                        state_d     = ST_FLUSH_REQ;
                        xfer_slot_d = cur_slot_q;
                        rel_blk_d   = '0;
                    end
                end
            end
            ST_LOAD_REQ:  if (sd_ack_i) state_d = ST_LOAD_WAIT;
            ST_FLUSH_REQ: if (sd_ack_i) state_d = ST_FLUSH_WAIT;
            ST_LOAD_WAIT: begin
                if (sd_ack_i && sd_buff_wr_i && is_hdr)
                    hdr_d[hdr_idx +: 8] = sd_buff_dout_i;
                if (ack_fall) begin
                    if (rel_blk_q == '0) n_blk_d = n_calc;
                    if (last_blk) begin
                        state_d    = ST_IDLE;
                        ready_d    = mount_pend_q;
                        cur_slot_d = xfer_slot_q;
                    end else begin
                        state_d   = ST_LOAD_REQ;
                        rel_blk_d = rel_blk_q + NB_W'(1);
                    end
                end
            end
            ST_FLUSH_WAIT: begin
                if (sd_ack_i)
                    din_src_d = is_hdr ? DIN_HDR : (in_range ? DIN_BRAM : DIN_ZERO);
                if (ack_fall) begin
                    if (last_blk) begin
                        state_d = ST_IDLE;
                        dirty_d = 1'b0;
                    end else begin
                        state_d   = ST_FLUSH_REQ;
                        rel_blk_d = rel_blk_q + NB_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bit_count_d  = hdr_d[8*HDR_BIT_OFS +: 32];
        byte_count_d = hdr_d[8*HDR_BYTE_OFS +: 32];

        if (state_d == ST_LOAD_REQ || state_d == ST_FLUSH_REQ)
            lba_d = LBA_BASE + (32'(xfer_slot_d) << BLK_SHIFT) + 32'(rel_blk_d);

        // A media change discards everything, including unsaved writes.
        if (change_rise) begin
            state_d      = ST_IDLE;
            ready_d      = 1'b0;
            dirty_d      = 1'b0;
            bit_count_d  = '0;
            byte_count_d = '0;
            rel_blk_d    = '0;
            mount_pend_d = mount_i;
            cur_slot_d   = '1;
            din_src_d    = DIN_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_slot_q   <= '1;
            xfer_slot_q  <= '0;
            rel_blk_q    <= '0;
            n_blk_q      <= '0;
            bit_count_q  <= '0;
            byte_count_q <= '0;
            ready_q      <= 1'b0;
            dirty_q      <= 1'b0;
            mount_pend_q <= 1'b0;
            lba_q        <= '0;
            change_q     <= 1'b0;
            ack_q        <= 1'b0;
            din_src_q    <= DIN_ZERO;
            hdr_q        <= '0;
        end else begin
            state_q      <= state_d;
            cur_slot_q   <= cur_slot_d;
            xfer_slot_q  <= xfer_slot_d;
            rel_blk_q    <= rel_blk_d;
            n_blk_q      <= n_blk_d;
            bit_count_q  <= bit_count_d;
            byte_count_q <= byte_count_d;
            ready_q      <= ready_d;
            dirty_q      <= dirty_d;
            mount_pend_q <= mount_pend_d;
            lba_q        <= lba_d;
            change_q     <= change_i;
            ack_q        <= sd_ack_i;
            din_src_q    <= din_src_d;
            hdr_q        <= hdr_word[hdr_idx +: 8];
        end
    end

    woz_track_bram #(.ADDR_W(ADDR_W)) u_bram (
        .clk      (clk),
        .a_we_i   (a_we),
        .a_addr_i (map_addr[ADDR_W-1:0]),
        .a_din_i  (sd_buff_dout_i),
        .a_dout_o (a_dout),
        .b_we_i   (drv_we),
        .b_addr_i (bit_byte_addr_i),
        .b_din_i  (bit_byte_din_i),
        .b_dout_o (b_dout)
    );

    assign sd_lba_o        = lba_q;
    assign sd_rd_o         = (state_q == ST_LOAD_REQ);
    assign sd_wr_o         = (state_q == ST_FLUSH_REQ);
    assign busy_o          = (state_q != ST_IDLE);
    assign ready_o         = ready_q;
    assign dirty_o         = dirty_q;
    assign bit_count_o     = bit_count_q;
    assign state_o         = state_q;
    assign bit_byte_data_o = ready_q ? b_dout : 8'h00;
    assign sd_buff_din_o   = (din_src_q == DIN_HDR)  ? hdr_q  :
                             (din_src_q == DIN_BRAM) ? a_dout : 8'h00;

endmodule
